// File: rtl/led_pkg.sv
// Shared definitions for the LED fade output stage.
package led_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } led_state_e;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEF_PWM_BITS  = 8;
    localparam int DEF_RAMP_STEP = 19_531;

    // Prescaler width that stays legal for RAMP_STEP == 1
    function automatic int presc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// LED level request in, PWM pin and ramp status out.
interface led_fade_driver_if
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
);
    logic                LED_In;
    logic                Enable;
    logic                LED_Pwm;
    logic [PWM_BITS-1:0] Level;
    logic                Busy;

    modport master (
        output LED_In, Enable,
        input  LED_Pwm, Level, Busy
    );

    modport slave (
        input  LED_In, Enable,
        output LED_Pwm, Level, Busy
    );
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running 255-clock PWM with a shadow level latched at period start.
module led_pwm_gen
    import led_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                Clear,
    input  logic [PWM_BITS-1:0] Level,
    output logic                LED_Pwm
);
    localparam logic [PWM_BITS-1:0] CNT_LAST =
        {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] shadow;
    logic                raw;

    assign raw = (cnt < shadow);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt     <= '0;
            shadow  <= '0;
            LED_Pwm <= ACTIVE_LOW;
        end else begin
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            LED_Pwm <= raw ^ ACTIVE_LOW;
            if (Clear)
                shadow <= '0;
            else if (cnt == '0)
                shadow <= Level;
        end
    end
endmodule

// File: rtl/led_fade_driver.sv
// Turns an on/off LED request into linear PWM brightness ramps.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int RAMP_STEP  = DEF_RAMP_STEP,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic              CLK,
    input logic              RSTn,
    led_fade_driver_if.slave bus
);
    localparam int PSW = presc_width(RAMP_STEP);
    localparam logic [PSW-1:0] PS_LAST = PSW'(RAMP_STEP - 1);
    localparam logic [PWM_BITS-1:0] MAX_LVL = '1;
    localparam logic [PWM_BITS-1:0] ONE_LVL = PWM_BITS'(1);

    led_state_e          state, state_n;
    logic [PWM_BITS-1:0] level, level_n;
    logic [PSW-1:0]      presc, presc_n;
    logic                r_in;
    logic                tick;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_OFF;
            level <= '0;
            presc <= '0;
            r_in  <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            presc <= presc_n;
            r_in  <= bus.LED_In;
        end
    end

    // Prescaler defaults to 0, so any transition or idle state clears it
    always_comb begin
        state_n = state;
        level_n = level;
        presc_n = '0;
        tick    = (presc == PS_LAST);
        if (!bus.Enable) begin
            state_n = S_OFF;
            level_n = '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    if (r_in)
                        state_n = S_RISE;
                end
                S_RISE: begin
                    if (!r_in) begin
                        state_n = S_FALL;
                    end else if (tick) begin
                        if (level >= MAX_LVL - 1'b1) begin
                            level_n = MAX_LVL;
                            state_n = S_ON;
                        end else begin
                            level_n = level + 1'b1;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                S_ON: begin
                    if (!r_in)
                        state_n = S_FALL;
                end
                S_FALL: begin
                    if (r_in) begin
                        state_n = S_RISE;
                    end else if (tick) begin
                        if (level <= ONE_LVL) begin
                            level_n = '0;
                            state_n = S_OFF;
                        end else begin
                            level_n = level - 1'b1;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                default: state_n = S_OFF;
            endcase
        end
    end

    assign bus.Level = level;
    assign bus.Busy  = (state == S_RISE) || (state == S_FALL);

    led_pwm_gen #(
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_pwm (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .Clear   (!bus.Enable),
        .Level   (level),
        .LED_Pwm (bus.LED_Pwm)
    );
endmodule

// File: tb/tb_led_fade_driver.sv
// Random and directed checks of led_fade_driver against a goal-tracking model.
module tb_led_fade_driver;
    localparam int RS_A = 4;
    localparam int AL_A = 0;

    logic CLK = 1'b0;
    logic rst_a, rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mon_on = 0;

    always #5 CLK = ~CLK;

    led_fade_driver_if #(.PWM_BITS(8)) a_if ();
    led_fade_driver_if #(.PWM_BITS(8)) b_if ();

    led_fade_driver #(
        .PWM_BITS(8), .RAMP_STEP(RS_A), .ACTIVE_LOW(1'b0)
    ) u_a (
        .CLK(CLK), .RSTn(rst_a), .bus(a_if)
    );

    led_fade_driver #(
        .PWM_BITS(8), .RAMP_STEP(1), .ACTIVE_LOW(1'b1)
    ) u_b (
        .CLK(CLK), .RSTn(rst_b), .bus(b_if)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int stepv(input int l, input int g);
        int v;
        v = (g == 255) ? l + 1 : l - 1;
        if (v > 255) v = 255;
        if (v < 0) v = 0;
        return v;
    endfunction

    // Model: brightness walks toward a goal (0 or 255) one level per
    // RAMP_STEP clocks; a new goal restarts the step timer.
    int m_in, m_lvl, m_goal, m_busy, m_wait, m_pc, m_sh, m_pin;

    always @(posedge CLK or negedge rst_a) begin
        if (!rst_a) begin
            m_in <= 0; m_lvl <= 0; m_goal <= 0; m_busy <= 0;
            m_wait <= 0; m_pc <= 0; m_sh <= 0; m_pin <= AL_A;
        end else begin
            m_in  <= int'(a_if.LED_In);
            m_pin <= ((m_pc < m_sh) ? 1 : 0) ^ AL_A;
            m_pc  <= (m_pc == 254) ? 0 : m_pc + 1;
            if (!a_if.Enable) begin
                m_lvl <= 0; m_goal <= 0; m_busy <= 0;
                m_wait <= 0; m_sh <= 0;
            end else begin
                if (m_pc == 0) m_sh <= m_lvl;
                if ((m_in != 0 ? 255 : 0) != m_goal) begin
                    m_goal <= (m_in != 0) ? 255 : 0;
                    m_busy <= 1;
                    m_wait <= 0;
                end else if (m_busy != 0) begin
                    if (m_wait == RS_A - 1) begin
                        m_lvl  <= stepv(m_lvl, m_goal);
                        m_wait <= 0;
                        if (stepv(m_lvl, m_goal) == m_goal) m_busy <= 0;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_on != 0) begin
            chk("m_lvl", int'(a_if.Level), m_lvl);
            chk("m_busy", int'(a_if.Busy), m_busy);
            chk("m_pin", int'(a_if.LED_Pwm), m_pin);
        end
    end

    task automatic wait_lvl(input string tag, input int tgt, input int lim);
        int n;
        n = 0;
        while (int'(a_if.Level) != tgt && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, int'(a_if.Level), tgt);
    endtask

    initial begin
        int cnt, hold;
        a_if.LED_In = 1'b1; a_if.Enable = 1'b1;
        b_if.LED_In = 1'b1; b_if.Enable = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        mon_on = 1;
        repeat (5) begin
            @(negedge CLK);
            chk("rst_pin_a", int'(a_if.LED_Pwm), 0);
            chk("rst_lvl_a", int'(a_if.Level), 0);
            chk("rst_busy_a", int'(a_if.Busy), 0);
            chk("rst_pin_b", int'(b_if.LED_Pwm), 1);
        end
        a_if.LED_In = 1'b0;
        rst_a = 1'b1;
        repeat (3) @(negedge CLK);

        // Full rise: busy on the 2nd edge, 255 after 1020 clocks
        a_if.LED_In = 1'b1;
        @(negedge CLK);
        chk("busy_edge1", int'(a_if.Busy), 0);
        @(negedge CLK);
        chk("busy_edge2", int'(a_if.Busy), 1);
        repeat (1019) @(negedge CLK);
        chk("rise_254", int'(a_if.Level), 254);
        chk("rise_busy", int'(a_if.Busy), 1);
        @(negedge CLK);
        chk("rise_255", int'(a_if.Level), 255);
        chk("rise_done", int'(a_if.Busy), 0);
        repeat (510) @(negedge CLK);
        cnt = 0;
        repeat (255) begin
            @(negedge CLK);
            cnt += int'(a_if.LED_Pwm);
        end
        chk("full_on", cnt, 255);

        // Fall, then reverse at 100
        a_if.LED_In = 1'b0;
        wait_lvl("fall0", 0, 1100);
        chk("fall_busy", int'(a_if.Busy), 0);
        a_if.LED_In = 1'b1;
        wait_lvl("up100", 100, 500);
        a_if.LED_In = 1'b0;
        wait_lvl("rev99", 99, 12);
        wait_lvl("rev0", 0, 500);
        repeat (8) @(negedge CLK);

        // Tick and direction change land on the same edge
        a_if.LED_In = 1'b1;
        repeat (4) @(negedge CLK);
        a_if.LED_In = 1'b0;
        repeat (2) @(negedge CLK);
        chk("coin_lvl", int'(a_if.Level), 0);
        chk("coin_busy", int'(a_if.Busy), 1);
        repeat (10) @(negedge CLK);

        // Enable drop mid-rise
        a_if.LED_In = 1'b1;
        wait_lvl("up150", 150, 700);
        a_if.Enable = 1'b0;
        @(negedge CLK);
        chk("en_lvl", int'(a_if.Level), 0);
        chk("en_busy", int'(a_if.Busy), 0);
        @(negedge CLK);
        chk("en_pin", int'(a_if.LED_Pwm), 0);
        repeat (5) @(negedge CLK);
        a_if.Enable = 1'b1;
        @(negedge CLK);
        chk("reen_busy", int'(a_if.Busy), 1);
        chk("reen_lvl0", int'(a_if.Level), 0);
        repeat (4) @(negedge CLK);
        chk("reen_lvl1", int'(a_if.Level), 1);

        // Randomized toggling against the model
        for (int s = 0; s < 300; s++) begin
            hold = ($urandom_range(0, 7) == 0) ?
                   $urandom_range(200, 1100) : $urandom_range(1, 12);
            a_if.LED_In = 1'($urandom_range(0, 1));
            a_if.Enable = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            repeat (hold) @(negedge CLK);
        end
        a_if.Enable = 1'b1;

        // RAMP_STEP=1, active-low instance
        b_if.LED_In = 1'b1;
        rst_b = 1'b1;
        cnt = 0;
        while (b_if.Busy !== 1'b1 && cnt < 10) begin
            @(negedge CLK);
            cnt++;
        end
        chk("b_busy", int'(b_if.Busy), 1);
        cnt = 0;
        while (int'(b_if.Level) != 255 && cnt < 400) begin
            @(negedge CLK);
            cnt++;
        end
        chk("b_ramp_len", cnt, 255);
        b_if.LED_In = 1'b0;
        repeat (60) @(negedge CLK);
        chk("b_falling", int'(b_if.Busy), 1);
        #2 rst_b = 1'b0;
        #1;
        chk("b_arst_lvl", int'(b_if.Level), 0);
        chk("b_arst_busy", int'(b_if.Busy), 0);
        chk("b_arst_pin", int'(b_if.LED_Pwm), 1);

        repeat (3) @(negedge CLK);
        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
